// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// I2S transmitter: bit clock and word select come straight from a free-running MCLK divider;
// each channel is double-buffered (staging -> shift register) and swapped once per stereo frame.
module i2s_tx (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic [23:0] LEFT_TX,
    input  logic [23:0] RIGHT_TX,
    input  logic        LEFT_TX_VALID,
    input  logic        RIGHT_TX_VALID,
    input  logic        TX_EN,
    output logic        SCLK,
    output logic        LRCK,
    output logic        SDOUT,
    output logic        FRAME_REQ,
    output logic        UNDERRUN
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned CNT_W    = 9;
    localparam int unsigned SLOT_W   = 5;
    localparam logic [SLOT_W-1:0] SLOT_MSB = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LSB = SLOT_W'(SAMPLE_W);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                capture_c;
    logic                slot_tick_c;
    logic [SLOT_W-1:0]   slot_nxt_c;
    logic                lr_nxt_c;
    logic                slot_data_c;

    logic [SAMPLE_W-1:0] stage_l;
    logic [SAMPLE_W-1:0] stage_r;
    logic                fresh_l;
    logic                fresh_r;
    logic [SAMPLE_W-1:0] shift_l;
    logic [SAMPLE_W-1:0] shift_r;
    logic                sdout_q;
    logic                frame_req_q;
    logic                underrun_q;

    // SDOUT is loaded one MCLK ahead of the slot it belongs to, so decode the upcoming slot.
    always_comb begin
        cnt_nxt_c   = cnt + CNT_W'(1);
        capture_c   = (cnt == '1);
        slot_tick_c = (cnt[2:0] == 3'b111);
        slot_nxt_c  = cnt_nxt_c[7:3];
        lr_nxt_c    = cnt_nxt_c[8];
        slot_data_c = (slot_nxt_c >= SLOT_MSB) && (slot_nxt_c <= SLOT_LSB);
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

    // A VALID on the capture cycle lands after the clear, so it belongs to the next frame.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_l <= '0;
            stage_r <= '0;
            fresh_l <= 1'b0;
            fresh_r <= 1'b0;
        end else begin
            if (capture_c) begin
                fresh_l <= 1'b0;
                fresh_r <= 1'b0;
            end
            if (LEFT_TX_VALID) begin
                stage_l <= LEFT_TX;
                fresh_l <= 1'b1;
            end
            if (RIGHT_TX_VALID) begin
                stage_r <= RIGHT_TX;
                fresh_r <= 1'b1;
            end
        end
    end

    // Capture coincides with the slot-0 tick, so it never collides with a data shift.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_l <= '0;
            shift_r <= '0;
        end else if (capture_c) begin
            shift_l <= TX_EN ? stage_l : '0;
            shift_r <= TX_EN ? stage_r : '0;
        end else if (slot_tick_c && slot_data_c) begin
            if (lr_nxt_c) begin
                shift_r <= {shift_r[SAMPLE_W-2:0], 1'b0};
            end else begin
                shift_l <= {shift_l[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            sdout_q     <= 1'b0;
            frame_req_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            if (slot_tick_c) begin
                if (slot_data_c) begin
                    sdout_q <= lr_nxt_c ? shift_r[SAMPLE_W-1] : shift_l[SAMPLE_W-1];
                end else begin
                    sdout_q <= 1'b0;
                end
            end
            frame_req_q <= capture_c;
            underrun_q  <= capture_c && !(fresh_l && fresh_r);
        end
    end

    assign SCLK      = cnt[2];
    assign LRCK      = cnt[8];
    assign SDOUT     = sdout_q;
    assign FRAME_REQ = frame_req_q;
    assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Self-checking bench for i2s_tx: a monitor deserialises each half-frame into a received
// queue, and each test pushes the words it expects to see onto a scoreboard queue.
module tb_i2s_tx;

    typedef struct packed {
        logic        lr;
        logic [31:0] word;
    } hf_t;

    logic        MCLK;
    logic        RST_N;
    logic [23:0] LEFT_TX;
    logic [23:0] RIGHT_TX;
    logic        LEFT_TX_VALID;
    logic        RIGHT_TX_VALID;
    logic        TX_EN;
    logic        SCLK;
    logic        LRCK;
    logic        SDOUT;
    logic        FRAME_REQ;
    logic        UNDERRUN;

    int          vectors;
    int          miscompares;
    logic [8:0]  tcnt;
    logic        past_first;
    int          hf_bits;
    logic [31:0] hf_word;
    hf_t         rx_q[$];
    hf_t         exp_q[$];

    i2s_tx dut (
        .MCLK          (MCLK),
        .RST_N         (RST_N),
        .LEFT_TX       (LEFT_TX),
        .RIGHT_TX      (RIGHT_TX),
        .LEFT_TX_VALID (LEFT_TX_VALID),
        .RIGHT_TX_VALID(RIGHT_TX_VALID),
        .TX_EN         (TX_EN),
        .SCLK          (SCLK),
        .LRCK          (LRCK),
        .SDOUT         (SDOUT),
        .FRAME_REQ     (FRAME_REQ),
        .UNDERRUN      (UNDERRUN)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    // Reference frame position, restarted by reset exactly like the design's counter.
    always @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt       <= 9'd0;
            past_first <= 1'b0;
        end else begin
            if (tcnt == 9'd511) past_first <= 1'b1;
            tcnt <= tcnt + 9'd1;
        end
    end

    // Clock/strobe checks every cycle; SDOUT sampled mid-slot on SCLK high.
    always @(negedge MCLK) begin
        if (!RST_N) begin
            hf_bits = 0;
        end else begin
            vectors++;
            if (SCLK !== tcnt[2]) begin
                miscompares++;
                $display("FAIL sclk cnt=%0d got %b expected %b", tcnt, SCLK, tcnt[2]);
            end
            vectors++;
            if (LRCK !== tcnt[8]) begin
                miscompares++;
                $display("FAIL lrck cnt=%0d got %b expected %b", tcnt, LRCK, tcnt[8]);
            end
            vectors++;
            if (FRAME_REQ !== ((tcnt == 9'd0) && past_first)) begin
                miscompares++;
                $display("FAIL frame_req cnt=%0d got %b expected %b", tcnt, FRAME_REQ,
                         (tcnt == 9'd0) && past_first);
            end
            if (tcnt[2:0] == 3'd4) begin
                if (tcnt[7:3] == 5'd0) begin
                    hf_bits = 0;
                    hf_word = 32'd0;
                end
                hf_word = {hf_word[30:0], SDOUT};
                hf_bits++;
                if (tcnt[7:3] == 5'd31 && hf_bits == 32)
                    rx_q.push_back(hf_t'({tcnt[8], hf_word}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Expected half-frame: slot 0 delay bit, 24 sample bits MSB first, 7 trailing zeros.
    function automatic logic [31:0] fmt(input logic [23:0] s);
        return {1'b0, s, 7'b0};
    endfunction

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        exp_q.push_back(hf_t'({1'b0, fmt(l)}));
        exp_q.push_back(hf_t'({1'b1, fmt(r)}));
    endtask

    task automatic wait_cnt(input logic [8:0] target);
        int n;
        n = 0;
        do begin
            @(negedge MCLK);
            n++;
        end while (tcnt != target && n < 1100);
        if (tcnt != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_cnt timeout cnt=%0d expected %0d", tcnt, target);
        end
    endtask

    task automatic drive(input logic le, input logic [23:0] l, input logic re, input logic [23:0] r);
        LEFT_TX        = l;
        RIGHT_TX       = r;
        LEFT_TX_VALID  = le;
        RIGHT_TX_VALID = re;
        @(negedge MCLK);
        LEFT_TX_VALID  = 1'b0;
        RIGHT_TX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge MCLK);
        vectors++;
        if ({SCLK, LRCK, SDOUT, FRAME_REQ, UNDERRUN} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b expected 00000",
                     {SCLK, LRCK, SDOUT, FRAME_REQ, UNDERRUN});
        end
        @(negedge MCLK);
        #2 RST_N = 1'b1;
    endtask

    task automatic test_clocks();
        int sr, le, bad_sp, bad_le, bad_lp, ones, lsr, llr;
        logic ps, pl;
        hf_t e, r;
        sr = 0; le = 0; bad_sp = 0; bad_le = 0; bad_lp = 0; ones = 0;
        lsr = -1; llr = -1; ps = 1'b0; pl = 1'b0;
        push_frame(24'd0, 24'd0);
        push_frame(24'd0, 24'd0);
        for (int c = 1; c <= 1024; c++) begin
            @(negedge MCLK);
            if (SCLK && !ps) begin
                sr++;
                if (lsr >= 0 && c - lsr != 8) bad_sp++;
                lsr = c;
            end
            if (LRCK !== pl) begin
                le++;
                if (!(ps && !SCLK)) bad_le++;
                if (LRCK) begin
                    if (llr >= 0 && c - llr != 512) bad_lp++;
                    llr = c;
                end
            end
            if (SDOUT !== 1'b0) ones++;
            ps = SCLK;
            pl = LRCK;
        end
        vectors++;
        if (sr !== 128) begin miscompares++; $display("FAIL sclk_rises got %0d expected 128", sr); end
        vectors++;
        if (bad_sp !== 0) begin miscompares++; $display("FAIL sclk_period bad=%0d expected 0", bad_sp); end
        vectors++;
        if (le !== 4) begin miscompares++; $display("FAIL lrck_edges got %0d expected 4", le); end
        vectors++;
        if (bad_lp !== 0) begin miscompares++; $display("FAIL lrck_period bad=%0d expected 0", bad_lp); end
        vectors++;
        if (bad_le !== 0) begin miscompares++; $display("FAIL lrck_on_sclk_fall bad=%0d expected 0", bad_le); end
        vectors++;
        if (ones !== 0) begin miscompares++; $display("FAIL sdout_idle ones=%0d expected 0", ones); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL clocks_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL clocks_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
    endtask

    task automatic test_data();
        hf_t e, r;
        vectors++;
        if (UNDERRUN !== 1'b1) begin miscompares++; $display("FAIL data_first_underrun got %b expected 1", UNDERRUN); end
        push_frame(24'd0, 24'd0);
        wait_cnt(9'd100);
        drive(1'b1, 24'h800001, 1'b1, 24'h7FFFFE);
        push_frame(24'h800001, 24'h7FFFFE);
        wait_cnt(9'd0);
        vectors++;
        if (UNDERRUN !== 1'b0) begin miscompares++; $display("FAIL data_underrun got %b expected 0", UNDERRUN); end
        wait_cnt(9'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL data_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL data_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
        vectors++;
        if (rx_q.size() !== 0) begin miscompares++; $display("FAIL data_extra words=%0d expected 0", rx_q.size()); end
    endtask

    task automatic test_underrun();
        int ur_n, fr_n, ur_at;
        hf_t e, r;
        ur_n = 0; fr_n = 0; ur_at = -1;
        vectors++;
        if (UNDERRUN !== 1'b1) begin miscompares++; $display("FAIL stale_frame_underrun got %b expected 1", UNDERRUN); end
        push_frame(24'h800001, 24'h7FFFFE);
        wait_cnt(9'd40);
        drive(1'b1, 24'hA5A5A5, 1'b0, 24'h000000);
        push_frame(24'hA5A5A5, 24'h7FFFFE);
        wait_cnt(9'd0);
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge MCLK);
            if (UNDERRUN === 1'b1) begin ur_n++; ur_at = int'(tcnt); end
            if (FRAME_REQ === 1'b1) fr_n++;
        end
        vectors++;
        if (ur_n !== 1) begin miscompares++; $display("FAIL underrun_count got %0d expected 1", ur_n); end
        vectors++;
        if (ur_at !== 0) begin miscompares++; $display("FAIL underrun_position got %0d expected 0", ur_at); end
        vectors++;
        if (fr_n !== 1) begin miscompares++; $display("FAIL frame_req_count got %0d expected 1", fr_n); end
        wait_cnt(9'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL underrun_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL underrun_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
    endtask

    task automatic test_capture_edge();
        hf_t e, r;
        push_frame(24'hA5A5A5, 24'h7FFFFE);
        wait_cnt(9'd511);
        drive(1'b1, 24'h123456, 1'b0, 24'h000000);
        vectors++;
        if (UNDERRUN !== 1'b1) begin miscompares++; $display("FAIL edge_underrun got %b expected 1", UNDERRUN); end
        push_frame(24'hA5A5A5, 24'h7FFFFE);
        wait_cnt(9'd200);
        drive(1'b0, 24'h000000, 1'b1, 24'h3C3C3C);
        push_frame(24'h123456, 24'h3C3C3C);
        wait_cnt(9'd0);
        vectors++;
        if (UNDERRUN !== 1'b0) begin miscompares++; $display("FAIL edge_next_underrun got %b expected 0", UNDERRUN); end
        wait_cnt(9'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL edge_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL edge_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
    endtask

    task automatic test_tx_en();
        hf_t e, r;
        push_frame(24'h123456, 24'h3C3C3C);
        wait_cnt(9'd100);
        drive(1'b1, 24'h111111, 1'b1, 24'hC22222);
        wait_cnt(9'd300);
        TX_EN = 1'b0;
        wait_cnt(9'd0);
        vectors++;
        if (UNDERRUN !== 1'b0) begin miscompares++; $display("FAIL txen_underrun got %b expected 0", UNDERRUN); end
        push_frame(24'd0, 24'd0);
        wait_cnt(9'd300);
        TX_EN = 1'b1;
        push_frame(24'h111111, 24'hC22222);
        wait_cnt(9'd0);
        wait_cnt(9'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL txen_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL txen_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        hf_t e, r;
        exp_q.push_back(hf_t'({1'b0, fmt(24'h111111)}));
        wait_cnt(9'd50);
        drive(1'b1, 24'h654321, 1'b1, 24'h0ABCDE);
        wait_cnt(9'd270);
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if ({SCLK, LRCK, SDOUT, FRAME_REQ, UNDERRUN} !== 5'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got %b expected 00000",
                     {SCLK, LRCK, SDOUT, FRAME_REQ, UNDERRUN});
        end
        repeat (3) @(negedge MCLK);
        #2 RST_N = 1'b1;
        push_frame(24'd0, 24'd0);
        push_frame(24'd0, 24'd0);
        wait_cnt(9'd0);
        vectors++;
        if (UNDERRUN !== 1'b1) begin miscompares++; $display("FAIL midreset_underrun got %b expected 1", UNDERRUN); end
        wait_cnt(9'd100);
        drive(1'b1, 24'h654321, 1'b1, 24'h0ABCDE);
        push_frame(24'h654321, 24'h0ABCDE);
        wait_cnt(9'd0);
        wait_cnt(9'd0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL midreset_word missing lr=%0d expected %h", e.lr, e.word);
            end else begin
                r = rx_q.pop_front();
                if (r !== e) begin
                    miscompares++;
                    $display("FAIL midreset_word lr=%0d got %h expected lr=%0d %h", r.lr, r.word, e.lr, e.word);
                end
            end
        end
        vectors++;
        if (rx_q.size() !== 0) begin miscompares++; $display("FAIL midreset_extra words=%0d expected 0", rx_q.size()); end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        RST_N          = 1'b0;
        LEFT_TX        = 24'd0;
        RIGHT_TX       = 24'd0;
        LEFT_TX_VALID  = 1'b0;
        RIGHT_TX_VALID = 1'b0;
        TX_EN          = 1'b1;
        test_reset();
        test_clocks();
        test_data();
        test_underrun();
        test_capture_edge();
        test_tx_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have port MCLK, input, 1 bit: master clock, 22.5792 MHz; all logic on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port LEFT_TX, input, 24 bits: signed left sample from the filter path.
REQ-004 SHALL have port RIGHT_TX, input, 24 bits: signed right sample from the filter path.
REQ-005 SHALL have port LEFT_TX_VALID, input, 1 bit: one-MCLK strobe qualifying LEFT_TX.
REQ-006 SHALL have port RIGHT_TX_VALID, input, 1 bit: one-MCLK strobe qualifying RIGHT_TX.
REQ-007 SHALL have port TX_EN, input, 1 bit: when low, transmitted data is forced to zero while clocks keep running.
REQ-008 SHALL have port SCLK, output, 1 bit: serial bit clock, MCLK/8 (64 x fs).
REQ-009 SHALL have port LRCK, output, 1 bit: word select, MCLK/512 (44.1 kHz); low = left, high = right.
REQ-010 SHALL have port SDOUT, output, 1 bit: I2S serial data.
REQ-011 SHALL have port FRAME_REQ, output, 1 bit: one-MCLK pulse at each stereo frame capture.
REQ-012 SHALL have port UNDERRUN, output, 1 bit: one-MCLK pulse when a frame is captured with a stale channel.

Function
REQ-013 SHALL contain a 9-bit free-running counter CNT that increments every MCLK and wraps from 511 to 0.
REQ-014 SHALL drive SCLK = CNT[2] and LRCK = CNT[8] directly from counter flops (glitch-free, no extra logic).
REQ-015 SHALL define slot k = CNT[7:3] (0..31) within each half-frame, so that SCLK falling edges coincide with slot boundaries.
REQ-016 SHALL hold one 24-bit staging register and one fresh flag per channel.
REQ-017 SHALL, on *_TX_VALID high, load that channel's staging register from its *_TX input and set its fresh flag.
REQ-018 SHALL perform frame capture on the cycle where CNT = 511: copy both staging registers into the left/right shift registers (zeroed if TX_EN = 0) and clear both fresh flags.
REQ-019 SHALL, if a VALID arrives on the capture cycle, write staging and set the fresh flag after the clear, so that the sample belongs to the next frame and the current capture uses the prior staging value.
REQ-020 SHALL pulse FRAME_REQ on the cycle after capture (CNT = 0).
REQ-021 SHALL pulse UNDERRUN on that same cycle if either fresh flag was clear at capture; the stale channel retransmits its previous staging value.
REQ-022 SHALL register SDOUT and update it only on cycles where CNT[2:0] becomes 0, so that it changes with SCLK falling and is stable across SCLK rising.
REQ-023 SHALL drive SDOUT during slot k of a half-frame as follows: slot 0 = 0 (I2S one-bit delay); slots 1..24 = sample bit [24-k] (MSB first); slots 25..31 = 0.
REQ-024 SHALL take the sample from the left shift register when LRCK = 0 and from the right shift register when LRCK = 1.
REQ-025 SHALL sample TX_EN only at capture, so that a mid-frame change never truncates a word.
REQ-026 SHALL fix latency as: left MSB on SDOUT at CNT = 8 after capture (9 MCLK); right MSB at CNT = 264.
REQ-027 SHALL transmit two's-complement bits unchanged, with no rounding or saturation.

Reset
REQ-028 SHALL, while RST_N = 0, clear CNT, staging, shift registers and fresh flags, and drive SCLK = 0, LRCK = 0, SDOUT = 0, FRAME_REQ = 0 and UNDERRUN = 0.
REQ-029 SHALL, after reset release, transmit zeros for the first frame; the first capture occurs at CNT = 511 (512 MCLK after release).
REQ-030 SHALL, on reset asserted mid-frame, clear all outputs immediately; no partial word is resumed after release.

Verification
REQ-031 SHALL verify: reset release, 1024 MCLK -> SCLK period 8 MCLK, LRCK period 512 MCLK, LRCK edges on SCLK falling, SDOUT = 0 throughout.
REQ-032 SHALL verify: LEFT_TX = 0x800001 and RIGHT_TX = 0x7FFFFE, both valid at CNT = 100 -> left slots 1..24 carry 1,0..0,1; right slots carry 0,1..1,0; slots 0 and 25..31 = 0; UNDERRUN = 0.
REQ-033 SHALL verify: only LEFT_TX_VALID in a frame -> UNDERRUN pulses once at CNT = 0; the right channel repeats its previous word; FRAME_REQ pulses every 512 MCLK.
REQ-034 SHALL verify: LEFT_TX_VALID with 0x123456 exactly at CNT = 511 -> the current frame sends the old value; 0x123456 is sent in the next frame with no UNDERRUN for left.
REQ-035 SHALL verify: TX_EN dropped at CNT = 300 -> the right word of the current frame completes intact; the next frame is all zeros; clocks are unaffected.
REQ-036 SHALL verify: RST_N pulsed low at CNT = 270 -> all outputs 0 asynchronously; after release the counter restarts at 0 and the first nonzero word appears only after the next capture.
